// File: rtl/ota_chop_if.sv
// Handshake/result bundle between the OTA chopper sequencer and its host.
// master = host side (drives controls, reads status); slave = sequencer side.
interface ota_chop_if #(
    parameter int CNT_W = 8,
    parameter int SET_W = 4
);
    logic             ena;
    logic             start;
    logic             cont;
    logic [CNT_W-1:0] win_len;
    logic [SET_W-1:0] settle;
    logic             cmp_in;
    logic             ota_en;
    logic             chop;
    logic             busy;
    logic             done;
    logic [CNT_W:0]   result;
    logic             decision;

    modport master (
        output ena, start, cont, win_len, settle, cmp_in,
        input  ota_en, chop, busy, done, result, decision
    );

    modport slave (
        input  ena, start, cont, win_len, settle, cmp_in,
        output ota_en, chop, busy, done, result, decision
    );
endinterface

// File: rtl/ota_chop_ctrl.sv
// Chopper/offset-cancelling measurement sequencer for the OTA comparator.
// Optional feature: define OTA_CHOP_CONT_EN to let DONE restart directly when cont=1.
module ota_chop_ctrl #(
    parameter int CNT_W = 8,
    parameter int SET_W = 4
) (
    input logic        clk,
    input logic        rst_n,
    ota_chop_if.slave  bus
);
    localparam int TMR_W = (CNT_W > SET_W) ? CNT_W : SET_W;

    typedef enum logic [2:0] {
        IDLE,
        SET_P,
        SMP_P,
        SET_N,
        SMP_N,
        DONE
    } state_e;

    state_e             state_q, state_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [CNT_W-1:0]   cnt_p_q, cnt_p_d;
    logic [CNT_W-1:0]   cnt_n_q, cnt_n_d;
    logic [CNT_W-1:0]   win_q, win_d;
    logic [SET_W-1:0]   set_q, set_d;
    logic [CNT_W:0]     result_q, result_d;
    logic               decision_q, decision_d;
    logic               sync1_q, sync1_d;
    logic               sync2_q, sync2_d;
    logic               cmp_sync;

`ifndef OTA_CHOP_CONT_EN
    logic unused_cont;
    assign unused_cont = bus.cont;
`endif

    assign sync1_d  = bus.cmp_in;
    assign sync2_d  = sync1_q;
    assign cmp_sync = sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tmr_q      <= '0;
            cnt_p_q    <= '0;
            cnt_n_q    <= '0;
            win_q      <= '0;
            set_q      <= '0;
            result_q   <= '0;
            decision_q <= 1'b0;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            cnt_p_q    <= cnt_p_d;
            cnt_n_q    <= cnt_n_d;
            win_q      <= win_d;
            set_q      <= set_d;
            result_q   <= result_d;
            decision_q <= decision_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
        end
    end

    // tmr_q counts down the remaining cycles of the current settle/sample phase.
    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q;
        cnt_p_d    = cnt_p_q;
        cnt_n_d    = cnt_n_q;
        win_d      = win_q;
        set_d      = set_q;
        result_d   = result_q;
        decision_d = decision_q;

        if (!bus.ena) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start && (bus.win_len != '0)) begin
                        win_d   = bus.win_len;
                        set_d   = bus.settle;
                        tmr_d   = TMR_W'(bus.settle);
                        cnt_p_d = '0;
                        cnt_n_d = '0;
                        state_d = SET_P;
                    end
                end
                SET_P: begin
                    if (tmr_q == '0) begin
                        tmr_d   = TMR_W'(win_q) - TMR_W'(1);
                        state_d = SMP_P;
                    end else begin
                        tmr_d = tmr_q - TMR_W'(1);
                    end
                end
                SMP_P: begin
                    if (cmp_sync) begin
                        cnt_p_d = cnt_p_q + CNT_W'(1);
                    end
                    if (tmr_q == '0) begin
                        tmr_d   = TMR_W'(set_q);
                        state_d = SET_N;
                    end else begin
                        tmr_d = tmr_q - TMR_W'(1);
                    end
                end
                SET_N: begin
                    if (tmr_q == '0) begin
                        tmr_d   = TMR_W'(win_q) - TMR_W'(1);
                        state_d = SMP_N;
                    end else begin
                        tmr_d = tmr_q - TMR_W'(1);
                    end
                end
                SMP_N: begin
                    // Swapped inputs: a true positive now reads as 0, so count zeros.
                    if (!cmp_sync) begin
                        cnt_n_d = cnt_n_q + CNT_W'(1);
                    end
                    if (tmr_q == '0) begin
                        result_d   = {1'b0, cnt_p_q} + {1'b0, cnt_n_d};
                        decision_d = (result_d > {1'b0, win_q});
                        state_d    = DONE;
                    end else begin
                        tmr_d = tmr_q - TMR_W'(1);
                    end
                end
                DONE: begin
`ifdef OTA_CHOP_CONT_EN
                    if (bus.cont) begin
                        tmr_d   = TMR_W'(set_q);
                        cnt_p_d = '0;
                        cnt_n_d = '0;
                        state_d = SET_P;
                    end else begin
                        state_d = IDLE;
                    end
`else
                    state_d = IDLE;
`endif
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.ota_en   = (state_q == SET_P) || (state_q == SMP_P) ||
                       (state_q == SET_N) || (state_q == SMP_N);
        bus.chop     = (state_q == SET_N) || (state_q == SMP_N);
        bus.busy     = (state_q != IDLE);
        bus.done     = (state_q == DONE);
        bus.result   = result_q;
        bus.decision = decision_q;
    end
endmodule

// File: tb/tb_ota_chop_ctrl.sv
// Directed + randomized bench for ota_chop_ctrl with a cycle-indexed reference model.
module tb_ota_chop_ctrl;
    localparam int CNT_W = 8;
    localparam int SET_W = 4;
`ifdef OTA_CHOP_CONT_EN
    localparam bit CONT = 1'b1;
`else
    localparam bit CONT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   miscompares = 0;
    bit   hist [1024];
    logic [CNT_W:0] prev_res;
    logic           prev_dec;
    int   done_cyc, chop_cnt;

    ota_chop_if #(.CNT_W(CNT_W), .SET_W(SET_W)) bus ();

    ota_chop_ctrl #(.CNT_W(CNT_W), .SET_W(SET_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_ota_en"}, 32'(bus.ota_en), 0);
        chk({tag, "_chop"},   32'(bus.chop),   0);
        chk({tag, "_busy"},   32'(bus.busy),   0);
        chk({tag, "_done"},   32'(bus.done),   0);
    endtask

    // One measurement. Cycle j is the clock period that ends at edge E_j; E_0 samples start.
    // mode: 0 random cmp_in, 1 cmp_in = ~chop, 2 cmp_in stuck at 1.
    task automatic run_meas(input int s, input int w, input int mode, input int abort_at,
                            input bit mid_start, output int dcyc, output int ccnt);
        int L, sp0, sn0, smn0, cp, cn;
        bit aborted, in_run, e_busy, e_ota, e_chop, e_done;
        logic [CNT_W:0] new_res;
        logic           new_dec;
        L    = 2 * (s + 1) + 2 * w + 1;
        sp0  = s + 2;
        sn0  = s + w + 2;
        smn0 = 2 * s + w + 3;
        dcyc = -1;
        ccnt = 0;
        new_res = prev_res;
        new_dec = prev_dec;
        for (int j = 0; j <= L + 1; j++) begin
            aborted = (abort_at > 0) && (j > abort_at);
            in_run  = (j >= 1) && (j <= L) && !aborted;
            e_busy  = in_run;
            e_ota   = in_run && (j < L);
            e_chop  = in_run && (j >= sn0) && (j < L);
            e_done  = in_run && (j == L);
            if (e_done) begin
                cp = 0;
                cn = 0;
                for (int k = sp0; k < sp0 + w; k++) cp += int'(hist[k - 2]);
                for (int k = smn0; k < smn0 + w; k++) cn += int'(!hist[k - 2]);
                new_res = (CNT_W + 1)'(cp + cn);
                new_dec = ((cp + cn) > w);
            end
            chk("busy",   32'(bus.busy),   32'(e_busy));
            chk("ota_en", 32'(bus.ota_en), 32'(e_ota));
            chk("chop",   32'(bus.chop),   32'(e_chop));
            chk("done",   32'(bus.done),   32'(e_done));
            chk("result", 32'(bus.result), 32'(new_res));
            chk("decision", 32'(bus.decision), 32'(new_dec));
            if (bus.done === 1'b1 && dcyc < 0) dcyc = j;
            if (bus.chop === 1'b1) ccnt++;
            bus.start = (j == 0) || (mid_start && j == 3);
            bus.ena   = !((abort_at > 0) && (j == abort_at));
            if (j == 0) begin
                bus.win_len = CNT_W'(w);
                bus.settle  = SET_W'(s);
            end else begin
                bus.win_len = CNT_W'($urandom);
                bus.settle  = SET_W'($urandom);
            end
            case (mode)
                1:       bus.cmp_in = ~e_chop;
                2:       bus.cmp_in = 1'b1;
                default: bus.cmp_in = 1'($urandom);
            endcase
            hist[j] = bus.cmp_in;
            tick();
        end
        bus.ena  = 1'b1;
        prev_res = new_res;
        prev_dec = new_dec;
    endtask

    initial begin
        int s, w;
        bit e_busy, e_done;
        // Reset with random inputs: every output low.
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.ena     = 1'($urandom);
            bus.start   = 1'($urandom);
            bus.cont    = 1'($urandom);
            bus.win_len = CNT_W'($urandom);
            bus.settle  = SET_W'($urandom);
            bus.cmp_in  = 1'($urandom);
            tick();
            chk_idle_outputs("reset");
            chk("reset_result",   32'(bus.result),   0);
            chk("reset_decision", 32'(bus.decision), 0);
        end
        bus.ena = 1'b1; bus.start = 1'b0; bus.cont = 1'b0; bus.cmp_in = 1'b0;
        rst_n = 1'b1;
        prev_res = '0;
        prev_dec = 1'b0;
        tick();
        chk("post_reset_busy", 32'(bus.busy), 0);

        // True positive input: 2*(2+1)+2*4+1 = 15th cycle is DONE, result 8.
        run_meas(2, 4, 1, 0, 1'b0, done_cyc, chop_cnt);
        chk("tp_latency",  32'(done_cyc), 15);
        chk("tp_result",   32'(bus.result), 8);
        chk("tp_decision", 32'(bus.decision), 1);

        // Pure offset: tie gives decision 0; chop high for settle+1+win_len cycles.
        run_meas(2, 4, 2, 0, 1'b0, done_cyc, chop_cnt);
        chk("tie_result",   32'(bus.result), 4);
        chk("tie_decision", 32'(bus.decision), 0);
        chk("tie_chop_cycles", 32'(chop_cnt), 7);

        // win_len=0 start is ignored.
        bus.win_len = '0;
        bus.settle  = 4'd2;
        bus.start   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            bus.start = (i < 1);
            chk("wl0_busy", 32'(bus.busy), 0);
            chk("wl0_done", 32'(bus.done), 0);
        end

        // Start pulsed while busy: no restart, a single done pulse at the normal time.
        run_meas(3, 5, 0, 0, 1'b1, done_cyc, chop_cnt);
        chk("midstart_latency", 32'(done_cyc), 2 * 4 + 2 * 5 + 1);

        // Re-establish result 8, then abort during SMP_N (cycles 11..14).
        run_meas(2, 4, 1, 0, 1'b0, done_cyc, chop_cnt);
        run_meas(2, 4, 1, 12, 1'b0, done_cyc, chop_cnt);
        chk("abort_no_done", 32'(done_cyc), 32'hffff_ffff);
        chk("abort_result",  32'(bus.result), 8);

        // Asynchronous reset in the middle of SET_P.
        bus.win_len = 8'd4; bus.settle = 4'd2; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        chk("setp_busy", 32'(bus.busy), 1);
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("async_rst");
        chk("async_rst_result", 32'(bus.result), 0);
        tick();
        rst_n = 1'b1;
        prev_res = '0;
        prev_dec = 1'b0;
        tick();

        // Randomized measurements including window/settle extremes.
        for (int i = 0; i < 8; i++) begin
            s = int'($urandom_range(1, 15));
            w = int'($urandom_range(1, 40));
            run_meas(s, w, 0, 0, 1'b0, done_cyc, chop_cnt);
        end
        run_meas(0, 1, 0, 0, 1'b0, done_cyc, chop_cnt);
        run_meas(15, 255, 0, 0, 1'b0, done_cyc, chop_cnt);
        chk("max_latency", 32'(done_cyc), 2 * 16 + 2 * 255 + 1);

        // Continuous request: restarts every 9 cycles only when the feature is built in.
        bus.cmp_in  = 1'b1;
        bus.win_len = 8'd3;
        bus.settle  = 4'd0;
        bus.cont    = 1'b1;
        for (int j = 0; j <= 30; j++) begin
            e_busy = CONT ? (j >= 1 && j <= 27) : (j >= 1 && j <= 9);
            e_done = e_busy && (j % 9 == 0);
            chk("cont_busy", 32'(bus.busy), 32'(e_busy));
            chk("cont_done", 32'(bus.done), 32'(e_done));
            if (e_done) begin
                chk("cont_result",   32'(bus.result),   3);
                chk("cont_decision", 32'(bus.decision), 0);
            end
            bus.start = (j == 0);
            bus.cont  = (j < 20);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
